demux_sweep_ctrl: RTL and testbench

//   Upstream sequencer for the 1-to-8 demux (3-bit sel, 1-bit i, o[7] selected at sel=0).
//   On a start pulse, steps sel through all 8 channels, dwelling a programmable number of

---
 rtl/demux_sweep_ctrl.sv | 146 ++++++++++++++
 tb/tb_demux_sweep_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_sweep_ctrl.sv
// demux_sweep_ctrl: sequencer for a 1-to-8 demux.
// After a start pulse it steps sel through all eight channels. It holds each
// channel for a programmable dwell time and gates data_in onto i while it runs.
// It can run one sweep or sweep continuously, counting up or down.
// Optional feature: define SWEEP_CNT_EN to add the sweep_cnt[7:0] output,
// which counts completed sweeps.
module demux_sweep_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               data_in,
  output logic [2:0]         sel,
  output logic               i,
  output logic               busy,
  output logic               done,
  output logic               ch_step
`ifdef SWEEP_CNT_EN
  ,
  output logic [7:0]         sweep_cnt
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0] dwell_len_q, dwell_len_d;
  logic               mode_q, mode_d;
  logic               dir_q, dir_d;
  logic               ch_step_q, ch_step_d;
  logic               start_ok;    // start accepted this cycle
  logic               sweep_end;   // last channel finished its dwell
  logic               last_ch;
  logic               dwell_end;

  assign last_ch   = dir_q ? (sel_q == 3'd0) : (sel_q == 3'd7);
  assign dwell_end = (dwell_cnt_q == dwell_len_q - DWELL_W'(1));

  // Next-state logic for the sweep FSM and its channel/dwell counters.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and infers a latch.
    state_d     = state_q;
    sel_d       = sel_q;
    dwell_cnt_d = dwell_cnt_q;
    dwell_len_d = dwell_len_q;
    mode_d      = mode_q;
    dir_d       = dir_q;
    ch_step_d   = 1'b0;
    start_ok    = 1'b0;
    sweep_end   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          start_ok    = 1'b1;
          state_d     = ST_RUN;
          mode_d      = mode;
          dir_d       = dir;
          dwell_len_d = (dwell == '0) ? DWELL_W'(1) : dwell;
          dwell_cnt_d = '0;
          sel_d       = dir ? 3'd7 : 3'd0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          // Abort wins over a pending channel step; sel keeps its value.
          state_d = ST_IDLE;
        end else if (dwell_end) begin
          dwell_cnt_d = '0;
          if (last_ch) begin
            sweep_end = 1'b1;
            if (mode_q) begin
              sel_d     = dir_q ? 3'd7 : 3'd0;
              ch_step_d = 1'b1;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            sel_d     = dir_q ? sel_q - 3'd1 : sel_q + 3'd1;
            ch_step_d = 1'b1;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= 3'd0;
      dwell_cnt_q <= '0;
      dwell_len_q <= DWELL_W'(1);
      mode_q      <= 1'b0;
      dir_q       <= 1'b0;
      ch_step_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      dwell_cnt_q <= dwell_cnt_d;
      dwell_len_q <= dwell_len_d;
      mode_q      <= mode_d;
      dir_q       <= dir_d;
      ch_step_q   <= ch_step_d;
    end
  end

`ifdef SWEEP_CNT_EN
  logic [7:0] sweep_cnt_q, sweep_cnt_d;

  // Completed-sweep counter: cleared by an accepted start, wraps naturally.
  always_comb begin
    sweep_cnt_d = sweep_cnt_q;
    if (start_ok)       sweep_cnt_d = 8'd0;
    else if (sweep_end) sweep_cnt_d = sweep_cnt_q + 8'd1;
  end

  // Sweep counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sweep_cnt_q <= 8'd0;
    else        sweep_cnt_q <= sweep_cnt_d;
  end

  assign sweep_cnt = sweep_cnt_q;
`endif

  assign sel     = sel_q;
  assign busy    = (state_q == ST_RUN);
  assign i       = busy & data_in;
  assign done    = (state_q == ST_DONE);
  assign ch_step = ch_step_q;

endmodule

// File: tb/tb_demux_sweep_ctrl.sv
// tb_demux_sweep_ctrl: directed bench for demux_sweep_ctrl. Expected per-cycle
// outputs are queued as stimulus is driven and compared on the falling edge.
// SWEEP_CNT_EN builds also exercise the sweep counter.
module tb_demux_sweep_ctrl;

  typedef struct packed {
    logic [2:0] sel;
    logic       i;
    logic       busy;
    logic       done;
    logic       ch_step;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, mode, dir, data_in;
  logic [7:0] dwell;
  logic [2:0] sel;
  logic       i, busy, done, ch_step;
`ifdef SWEEP_CNT_EN
  logic [7:0] sweep_cnt;
`endif

  obs_t  exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  demux_sweep_ctrl #(.DWELL_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .mode    (mode),
    .dir     (dir),
    .dwell   (dwell),
    .data_in (data_in),
    .sel     (sel),
    .i       (i),
    .busy    (busy),
    .done    (done),
    .ch_step (ch_step)
`ifdef SWEEP_CNT_EN
    ,
    .sweep_cnt (sweep_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input logic [2:0] s, input logic ii,
                      input logic b, input logic d, input logic c);
    obs_t e;
    e.sel = s; e.i = ii; e.busy = b; e.done = d; e.ch_step = c;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_now();
    obs_t  exp_v, act;
    string tag;
    checks++;
    act = {sel, i, busy, done, ch_step};
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_underflow: observed=%h expected=queued entry", act);
    end else begin
      exp_v = exp_q.pop_front();
      tag   = tag_q.pop_front();
      assert (act === exp_v) else begin
        errors++;
        $display("FAIL %s: observed sel/i/busy/done/ch_step=%h expected=%h", tag, act, exp_v);
        $error("%s observed=%h expected=%h", tag, act, exp_v);
      end
    end
  endtask

  // One clock: inputs set before the call are sampled on this rising edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    check_now();
  endtask

`ifdef SWEEP_CNT_EN
  task automatic check_cnt(input string tag, input logic [7:0] exp_v);
    checks++;
    assert (sweep_cnt === exp_v) else begin
      errors++;
      $display("FAIL %s: observed sweep_cnt=%0d expected=%0d", tag, sweep_cnt, exp_v);
      $error("%s observed=%0d expected=%0d", tag, sweep_cnt, exp_v);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b1; start = 0; stop = 0; mode = 0; dir = 0; data_in = 0; dwell = 8'd0;
    #1 rst_n = 1'b0;
    push("reset_state", 3'd0, 0, 0, 0, 0);
    #1 check_now();
    @(negedge clk);
    rst_n = 1'b1;

    // Single up sweep, dwell 2; mid-run start and dwell change are ignored.
    mode = 0; dir = 0; dwell = 8'd2; start = 1;
    for (int c = 1; c <= 16; c++) begin
      if (c == 4) dwell = 8'd5;
      if (c == 6) start = 1;
      data_in = (c % 3 != 0);
      push("single_up_run", 3'((c - 1) / 2), data_in, 1, 0, (c >= 3) && (c % 2 == 1));
      cyc();
      start = 0;
    end
    data_in = 1;
    push("single_up_done", 3'd7, 0, 0, 1, 0);
    cyc();
    start = 1;  // sampled while in DONE: must not restart
    push("done_start_ignored", 3'd7, 0, 0, 0, 0);
    cyc();
    start = 0;
    push("idle_after_done", 3'd7, 0, 0, 0, 0);
    cyc();

    // start and stop together in IDLE keep it idle.
    start = 1; stop = 1;
    push("start_stop_idle", 3'd7, 0, 0, 0, 0);
    cyc();
    start = 0; stop = 0;
    push("start_stop_idle2", 3'd7, 0, 0, 0, 0);
    cyc();

    // Continuous down sweep, dwell 0 behaves as 1, wraps 0->7.
    mode = 1; dir = 1; dwell = 8'd0; data_in = 0; start = 1;
    for (int c = 1; c <= 12; c++) begin
      push("cont_down_run", 3'(8 - c), 0, 1, 0, c >= 2);
      cyc();
      start = 0;
    end
    stop = 1;
    push("cont_down_stop", 3'd4, 0, 0, 0, 0);
    cyc();
    stop = 0;

    // Stop while sel=3 in a continuous up sweep with dwell 3.
    mode = 1; dir = 0; dwell = 8'd3; data_in = 1; start = 1;
    for (int c = 1; c <= 11; c++) begin
      push("stop_run", 3'((c - 1) / 3), 1, 1, 0, (c > 1) && ((c - 1) % 3 == 0));
      cyc();
      start = 0;
    end
    stop = 1;
    push("stop_at_sel3", 3'd3, 0, 0, 0, 0);
    cyc();
    stop = 0;
    push("stop_idle_hold", 3'd3, 0, 0, 0, 0);
    cyc();

    // Asynchronous reset mid-run, between clock edges.
    mode = 1; dir = 1; dwell = 8'd0; start = 1;
    for (int c = 1; c <= 3; c++) begin
      push("prereset_run", 3'(8 - c), 1, 1, 0, c >= 2);
      cyc();
      start = 0;
    end
    #2 rst_n = 1'b0;
    push("async_reset", 3'd0, 0, 0, 0, 0);
    #1 check_now();
    @(negedge clk);
    rst_n = 1'b1;
    push("post_reset_idle", 3'd0, 0, 0, 0, 0);
    cyc();

`ifdef SWEEP_CNT_EN
    mode = 1; dir = 0; dwell = 8'd1; data_in = 0; start = 1;
    for (int c = 1; c <= 25; c++) begin
      push("cnt_run", 3'(c - 1), 0, 1, 0, c >= 2);
      cyc();
      start = 0;
      if (c == 8)  check_cnt("cnt_before_first", 8'd0);
      if (c == 9)  check_cnt("cnt_first_sweep", 8'd1);
      if (c == 25) check_cnt("cnt_three_sweeps", 8'd3);
    end
    stop = 1;
    push("cnt_stop", 3'd0, 0, 0, 0, 0);
    cyc();
    check_cnt("cnt_after_stop", 8'd3);
    stop = 0; start = 1;
    push("cnt_restart", 3'd0, 0, 1, 0, 0);
    cyc();
    start = 0;
    check_cnt("cnt_cleared_on_start", 8'd0);
`endif

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $display("FAIL scoreboard_leftover: observed=%0d entries expected=0", exp_q.size());
      $error("scoreboard leftover");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
